// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_unit
//  Brief    : Data-side memory: word RAM plus MMIO cycle counter, output
//             FIFO (valid/ready drain), status register and GPO register.
//             Loads are combinational; stores commit on the rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory_unit #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 10,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDRESS_SIZE-1:0] mem_address,
  input  logic [DATA_SIZE-1:0]    mem_wdata,
  output logic [DATA_SIZE-1:0]    mem_rdata,
  output logic [DATA_SIZE-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_SIZE-1:0]    gpo
);

  localparam int RAM_DEPTH = 1 << (ADDRESS_SIZE - 1);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [1:0] OFF_CYCLE  = 2'd0;
  localparam logic [1:0] OFF_FIFO   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_GPO    = 2'd3;

  // Storage arrays (never reset; contents are don't-care until written)
  logic [DATA_SIZE-1:0] ram_mem  [RAM_DEPTH];
  logic [DATA_SIZE-1:0] fifo_mem [FIFO_DEPTH];

  // Architectural registers
  logic [31:0]          cycle_q, cycle_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [DATA_SIZE-1:0] gpo_q, gpo_d;

  // Decode and FIFO control
  logic                    is_mmio;
  logic [1:0]              mmio_off;
  logic [ADDRESS_SIZE-2:0] ram_idx;
  logic                    ram_wr;
  logic                    fifo_wr;
  logic                    status_wr;
  logic                    gpo_wr;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    pop;
  logic                    push;

  // Address decode, FIFO handshake and next-state computation
  always_comb begin
    is_mmio    = mem_address[ADDRESS_SIZE-1];
    mmio_off   = mem_address[1:0];
    ram_idx    = mem_address[ADDRESS_SIZE-2:0];
    ram_wr     = mem_write && !is_mmio;
    fifo_wr    = mem_write && is_mmio && (mmio_off == OFF_FIFO);
    status_wr  = mem_write && is_mmio && (mmio_off == OFF_STATUS);
    gpo_wr     = mem_write && is_mmio && (mmio_off == OFF_GPO);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = !fifo_empty && out_ready;
    // A full FIFO can still accept a word when a pop frees a slot this cycle
    push       = fifo_wr && (!fifo_full || pop);

    cycle_d    = cycle_q + 32'd1;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    overflow_d = overflow_q;
    if (fifo_wr && !push) begin
      overflow_d = 1'b1;
    end else if (status_wr && mem_wdata[2]) begin
      overflow_d = 1'b0;
    end
    gpo_d      = gpo_wr ? mem_wdata : gpo_q;
  end

  // Register update with asynchronous active-low clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      gpo_q      <= '0;
    end else begin
      cycle_q    <= cycle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      gpo_q      <= gpo_d;
    end
  end

  // RAM store port
  always_ff @(posedge clock) begin
    if (ram_wr) begin
      ram_mem[ram_idx] <= mem_wdata;
    end
  end

  // FIFO storage write at the write pointer
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_wdata;
    end
  end

  // Combinational load path; sees pre-write state on a same-cycle store
  always_comb begin
    mem_rdata = '0;
    if (mem_read) begin
      if (!is_mmio) begin
        mem_rdata = ram_mem[ram_idx];
      end else begin
        case (mmio_off)
          OFF_CYCLE:  mem_rdata = DATA_SIZE'(cycle_q);
          OFF_FIFO:   mem_rdata = DATA_SIZE'(count_q);
          OFF_STATUS: mem_rdata = {{(DATA_SIZE-3){1'b0}}, overflow_q, fifo_full, fifo_empty};
          default:    mem_rdata = gpo_q;
        endcase
      end
    end
  end

  // FIFO head and GPO outputs
  always_comb begin
    out_valid = !fifo_empty;
    out_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
    gpo       = gpo_q;
  end

endmodule
`default_nettype wire
